// File: rtl/gpu_mem_responder_if.sv
// gpu_mem_responder_if: byte-wide Avalon-MM command/response bus.
interface gpu_mem_responder_if;
  logic [31:0] address;
  logic [7:0]  writedata;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [7:0]  readdata;
  logic        readdatavalid;
  modport master (output address, writedata, write, read, input waitrequest, readdata, readdatavalid);
  modport slave  (input address, writedata, write, read, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/gpu_mem_responder.sv
// gpu_mem_responder: Avalon-MM byte memory with programmable wait states and fixed-latency pipelined reads.
module gpu_mem_responder #(
  parameter int          DEPTH        = 4096,
  parameter int          ADDR_BITS    = $clog2(DEPTH),
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          WAIT_CYCLES  = 0,
  parameter int          READ_LATENCY = 2,
  parameter int          MAX_PENDING  = 4
) (
  input  logic                clock,
  input  logic                reset,
  gpu_mem_responder_if.slave  s1,
  output logic                err,
  input  logic                err_clear
);
  localparam int PW = $clog2(MAX_PENDING + 1);
  typedef enum logic [1:0] {IDLE, STALL, READY} state_t;
  state_t                  state, state_n;
  logic [3:0]              cnt, cnt_n;
  logic [PW-1:0]           pending;
  logic [7:0]              mem [DEPTH];
  logic [READ_LATENCY-1:0] vld;
  logic [7:0]              dat [READ_LATENCY];
  logic [31:0]             off;
  logic [ADDR_BITS-1:0]    idx;
  logic cmd, rd_only, in_win, bp, acc, rd_acc, wr_acc, ret, bad;
  assign off     = s1.address - BASE_ADDR;
  assign idx     = off[ADDR_BITS-1:0];
  assign in_win  = (s1.address >= BASE_ADDR) && (off < 32'(DEPTH));
  assign cmd     = s1.read | s1.write;
  // read+write together is treated as a write, so it never waits on read backpressure
  assign rd_only = s1.read & ~s1.write;
  assign bp      = (pending == PW'(MAX_PENDING)) & rd_only;
  assign acc     = cmd & ~s1.waitrequest;
  assign rd_acc  = acc & rd_only;
  assign wr_acc  = acc & s1.write;
  assign bad     = acc & (~in_win | (s1.read & s1.write));
  assign ret     = vld[READ_LATENCY-1];
  assign s1.readdatavalid = vld[READ_LATENCY-1];
  assign s1.readdata      = dat[READ_LATENCY-1];
  // the IDLE cycle that spots a new command is the first wait cycle, so STALL runs WAIT_CYCLES-1 cycles
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    s1.waitrequest = bp;
    case (state)
      IDLE: if (cmd && WAIT_CYCLES > 0) begin
        s1.waitrequest = 1'b1;
        state_n        = (WAIT_CYCLES == 1) ? READY : STALL;
        cnt_n          = 4'(WAIT_CYCLES - 1);
      end
      STALL: begin
        s1.waitrequest = 1'b1;
        cnt_n          = cmd ? cnt - 4'd1 : 4'd0;
        state_n        = !cmd ? IDLE : (cnt == 4'd1) ? READY : STALL;
      end
      READY:   state_n = (!cmd || !bp) ? IDLE : READY;
      default: state_n = IDLE;
    endcase
    if (reset) s1.waitrequest = 1'b1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= '0;
      vld     <= '0;
      err     <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) dat[i] <= 8'h00;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pending <= pending + PW'(rd_acc) - PW'(ret);
      err     <= bad | (err & ~err_clear);
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
      vld[0] <= rd_acc;
      dat[0] <= (rd_acc && in_win) ? mem[idx] : 8'h00;
    end
  end
  always_ff @(posedge clock)
    if (wr_acc && in_win) mem[idx] <= s1.writedata;
endmodule

// File: tb/tb_gpu_mem_responder.sv
// tb_gpu_mem_responder: three configurations driven by directed and random traffic against a transaction-level model.
module tb_gpu_mem_responder;
  localparam int N = 3;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;
  logic [31:0] addr [N];
  logic [7:0]  wdat [N];
  logic        rd [N], wr [N], eclr [N];
  logic        wreq [N], rvld [N], err_o [N];
  logic [7:0]  rdat [N];
  int          cfg_d  [N] = '{4096, 256, 64};
  logic [31:0] cfg_b  [N] = '{32'h0000_0000, 32'h0000_1000, 32'hFFFF_FFC0};
  int          cfg_w  [N] = '{0, 3, 0};
  int          cfg_l  [N] = '{2, 3, 4};
  int          cfg_mp [N] = '{4, 3, 2};
  for (genvar g = 0; g < N; g++) begin : u
    gpu_mem_responder_if bus ();
    assign bus.address   = addr[g];
    assign bus.writedata = wdat[g];
    assign bus.read      = rd[g];
    assign bus.write     = wr[g];
    assign wreq[g]       = bus.waitrequest;
    assign rvld[g]       = bus.readdatavalid;
    assign rdat[g]       = bus.readdata;
    gpu_mem_responder #(
      .DEPTH(g == 0 ? 4096 : g == 1 ? 256 : 64),
      .BASE_ADDR(g == 0 ? 32'h0000_0000 : g == 1 ? 32'h0000_1000 : 32'hFFFF_FFC0),
      .WAIT_CYCLES(g == 1 ? 3 : 0),
      .READ_LATENCY(g == 0 ? 2 : g == 1 ? 3 : 4),
      .MAX_PENDING(g == 0 ? 4 : g == 1 ? 3 : 2)
    ) dut (
      .clock(clock), .reset(reset), .s1(bus), .err(err_o[g]), .err_clear(eclr[g])
    );
  end
  typedef struct { int k; int due; logic [7:0] data; bit kn; } resp_t;
  resp_t      rq [$];
  logic [7:0] mm [N][4096];
  bit         known [N][4096];
  int         waited [N];
  bit         em [N];
  bit         acc [N];
  int         cyc, n_cmp, n_bad;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic string tg(string s, int k);
    return $sformatf("%s[%0d]", s, k);
  endfunction
  function automatic bit in_win(int k, logic [31:0] a);
    return (a >= cfg_b[k]) && ((a - cfg_b[k]) < 32'(cfg_d[k]));
  endfunction
  // one clock cycle: compare outputs against the model mid-cycle, then advance the model
  task automatic step();
    @(negedge clock);
    for (int k = 0; k < N; k++) begin
      bit cmd, rdo, elig, ew, ev;
      int pend, front;
      logic [31:0] off;
      cmd = rd[k] | wr[k];
      rdo = rd[k] & ~wr[k];
      pend = 0;
      front = -1;
      foreach (rq[i]) if (rq[i].k == k) begin
        if (front < 0) front = i;
        pend++;
      end
      elig = (cfg_w[k] == 0) || (waited[k] >= cfg_w[k]);
      ew = reset || (cmd && !elig) || (pend == cfg_mp[k] && rdo);
      ev = (front >= 0) && (rq[front].due == cyc);
      if (cmd || reset) check(tg("waitrequest", k), 32'(wreq[k]), 32'(ew));
      check(tg("readdatavalid", k), 32'(rvld[k]), 32'(ev));
      if (ev && rq[front].kn) check(tg("readdata", k), 32'(rdat[k]), 32'(rq[front].data));
      check(tg("err", k), 32'(err_o[k]), 32'(em[k]));
      acc[k] = !reset && cmd && !ew;
      if (reset) begin
        for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].k == k) rq.delete(i);
        waited[k] = 0;
        em[k] = 1'b0;
      end else begin
        if (ev) rq.delete(front);
        off = addr[k] - cfg_b[k];
        if (acc[k]) begin
          if (wr[k]) begin
            if (in_win(k, addr[k])) begin
              mm[k][off] = wdat[k];
              known[k][off] = 1'b1;
            end
          end else if (in_win(k, addr[k]))
            rq.push_back('{k, cyc + cfg_l[k], mm[k][off], known[k][off]});
          else
            rq.push_back('{k, cyc + cfg_l[k], 8'h00, 1'b1});
          waited[k] = 0;
        end else
          waited[k] = cmd ? waited[k] + 1 : 0;
        em[k] = (acc[k] && (!in_win(k, addr[k]) || (rd[k] && wr[k]))) || (em[k] && !eclr[k]);
      end
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) step();
  endtask
  task automatic issue(int k, bit r, bit w, logic [31:0] a, logic [7:0] d);
    int n;
    rd[k] = r; wr[k] = w; addr[k] = a; wdat[k] = d;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc[k] && n < 64);
    if (!acc[k]) check(tg("accept_timeout", k), 32'(acc[k]), 32'd1);
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      rd[k] = 0; wr[k] = 0; eclr[k] = 0; addr[k] = cfg_b[k]; wdat[k] = 0;
      waited[k] = 0; em[k] = 0; acc[k] = 0;
    end
    @(posedge clock);
    #1;
    idle(3);
    reset = 1'b0;
    idle(2);
    issue(0, 0, 1, 32'd3, 8'hA5);
    issue(0, 1, 0, 32'd3, 8'h00);
    idle(4);
    issue(0, 1, 0, 32'd4096, 8'h00);
    idle(3);
    eclr[0] = 1'b1; step(); eclr[0] = 1'b0;
    idle(1);
    eclr[0] = 1'b1; issue(0, 1, 0, 32'd4096, 8'h00); eclr[0] = 1'b0;
    idle(3);
    eclr[0] = 1'b1; step(); eclr[0] = 1'b0;
    issue(0, 1, 1, 32'd5, 8'h3C);
    idle(4);
    issue(0, 1, 0, 32'd5, 8'h00);
    idle(4);
    issue(0, 0, 1, 32'd7, 8'h5A);
    issue(0, 1, 0, 32'd7, 8'h00);
    reset = 1'b1; step(); reset = 1'b0;
    idle(6);
    issue(0, 1, 0, 32'd7, 8'h00);
    idle(4);
    issue(1, 0, 1, 32'h1000, 8'h77);
    issue(1, 0, 1, 32'h1001, 8'h78);
    rd[1] = 1'b1; addr[1] = 32'h1000;
    idle(10);
    rd[1] = 1'b0;
    idle(5);
    for (int i = 0; i < 3; i++) issue(2, 0, 1, cfg_b[2] + 32'(i), 8'h10 + 8'(i));
    issue(2, 0, 1, 32'hFFFF_FFFF, 8'hEE);
    for (int i = 0; i < 3; i++) issue(2, 1, 0, cfg_b[2] + 32'(i), 8'h00);
    issue(2, 1, 0, 32'hFFFF_FFFF, 8'h00);
    issue(2, 1, 0, 32'h0000_0000, 8'h00);
    idle(8);
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < N; k++) begin
        if (!((rd[k] || wr[k]) && !acc[k] && $urandom_range(0, 7) != 0)) begin
          int r, s;
          r = $urandom_range(0, 19);
          rd[k] = (r < 8) || (r == 19);
          wr[k] = (r >= 8 && r < 14) || (r == 19);
          s = $urandom_range(0, 15);
          addr[k] = (s == 0) ? cfg_b[k] + 32'(cfg_d[k]) : (s == 1) ? cfg_b[k] - 32'd1 :
                    (s < 9) ? cfg_b[k] + $urandom_range(0, 15) : cfg_b[k] + 32'(cfg_d[k] - 16) + $urandom_range(0, 15);
          wdat[k] = 8'($urandom);
        end
        eclr[k] = ($urandom_range(0, 9) == 0);
      end
      step();
    end
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin rd[k] = 0; wr[k] = 0; eclr[k] = 0; end
    idle(8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
